ahbl_trace_mon: RTL and testbench

Synthesizable multi-channel AHB-Lite transfer monitor for the ice40_sm SoC. It captures completed read and write transfers on up to NUM_CH AHB-Lite master ports, such as the CPU instruction and data ports, and pairs each address phase with its own channel's data phase, including wait states. Records pass an address-window filter, are timestamped, and are buffered in a FIFO drained through a valid/ready stream, e.g. toward a UART trace dumper. It sits beside the interconnect and observes the buses only; it never drives them.

---
 rtl/ahbl_trace_mon_if.sv | 26 ++
 rtl/ahbl_trace_mon.sv | 236 +++++++++++++++++++++++
 tb/tb_ahbl_trace_mon.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_trace_mon_if.sv
// ahbl_trace_mon_if
//   Bundle of the observed AHB-Lite master-port signals for NUM_CH channels.
//   Channel k occupies bits [2k+1:2k] of ch_htrans_i and [32k+31:32k] of the
//   32-bit buses.
//   master : side that drives the bus signals (SoC masters / testbench)
//   slave  : observing side (ahbl_trace_mon), inputs only
interface ahbl_trace_mon_if #(
    parameter int NUM_CH = 2
);
    logic [2*NUM_CH-1:0]  ch_htrans_i;
    logic [NUM_CH-1:0]    ch_hwrite_i;
    logic [32*NUM_CH-1:0] ch_haddr_i;
    logic [32*NUM_CH-1:0] ch_hwdata_i;
    logic [32*NUM_CH-1:0] ch_hrdata_i;
    logic [NUM_CH-1:0]    ch_hready_i;

    modport master (
        output ch_htrans_i, ch_hwrite_i, ch_haddr_i,
        output ch_hwdata_i, ch_hrdata_i, ch_hready_i
    );

    modport slave (
        input ch_htrans_i, ch_hwrite_i, ch_haddr_i,
        input ch_hwdata_i, ch_hrdata_i, ch_hready_i
    );
endinterface

// File: rtl/ahbl_trace_mon.sv
// ahbl_trace_mon
//   Passive multi-channel AHB-Lite transfer monitor. Each channel latches a
//   qualifying address phase, pairs it with its own data phase (wait states
//   included), and parks the finished record in a one-entry pending register.
//   A round-robin arbiter moves pending records into a show-ahead FIFO that is
//   drained through a valid/ready stream.
//
//   Optional feature macro: TRACE_TIMESTAMP_EN
//     defined   - free-running 32-bit cycle counter, records carry the
//                 completion timestamp on rec_ts_o
//     undefined - no counter, rec_ts_o tied to 0
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   en_i                capture enable for new address phases
//   clr_i               clears drop_cnt_o and ovf_o
//   bus                 observed AHB-Lite channels (slave modport)
//   filt_lo_i/filt_hi_i inclusive unsigned address window
//   rec_valid_o/rec_ready_i and rec_*_o   record stream (FIFO head)
//   drop_cnt_o          saturating count of records lost at the pending stage
//   ovf_o               sticky drop flag
//   level_o             FIFO occupancy
module ahbl_trace_mon #(
    parameter int  NUM_CH = 2,
    parameter int  DEPTH  = 16,
    localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    ahbl_trace_mon_if.slave      bus,
    input  logic [31:0]          filt_lo_i,
    input  logic [31:0]          filt_hi_i,
    output logic                 rec_valid_o,
    input  logic                 rec_ready_i,
    output logic [CHW-1:0]       rec_ch_o,
    output logic                 rec_write_o,
    output logic [31:0]          rec_addr_o,
    output logic [31:0]          rec_data_o,
    output logic [31:0]          rec_ts_o,
    output logic [15:0]          drop_cnt_o,
    output logic                 ovf_o,
    output logic [AW:0]          level_o
);

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic           write;
        logic [31:0]    addr;
        logic [31:0]    data;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0]    ts;
`endif
    } rec_t;

    logic [NUM_CH-1:0]       pend_vld;
    rec_t [NUM_CH-1:0]       pend_rec;
    logic [NUM_CH-1:0]       grant;
    logic [NUM_CH-1:0]       drop;
    logic                    push;
    logic                    pop;
    logic                    can_push;
    logic [CHW-1:0]          gnt_idx;
    logic [CHW-1:0]          rr_q, rr_d;

    logic [AW-1:0]           wptr_q, rptr_q;
    logic [AW:0]             cnt_q, cnt_d;
    rec_t                    mem_q [DEPTH];
    rec_t                    head;

    logic [15:0]             drop_q, drop_d;
    logic                    ovf_q, ovf_d;
    logic [16:0]             drop_sum;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]             ts_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) ts_q <= '0;
        else       ts_q <= ts_q + 32'd1;
    end
`endif

    // ---------------- per-channel address/data pairing ----------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [1:0]  htrans;
        logic        hready;
        logic [31:0] haddr;
        logic        hit, complete, accept;
        logic        armed_q, armed_d;
        logic        pend_vld_q, pend_vld_d;
        logic [31:0] addr_q;
        logic        write_q;
        rec_t        pend_q, pend_d;

        assign htrans = bus.ch_htrans_i[2*k +: 2];
        assign hready = bus.ch_hready_i[k];
        assign haddr  = bus.ch_haddr_i[32*k +: 32];

        // NONSEQ/SEQ only; an inverted window (lo > hi) can never match
        assign hit      = (htrans inside {2'b10, 2'b11}) && hready && en_i &&
                          (haddr >= filt_lo_i) && (haddr <= filt_hi_i);
        assign complete = armed_q && hready;
        // a pending slot being granted this cycle is free for the new record
        assign accept   = complete && (!pend_vld_q || grant[k]);
        assign drop[k]  = complete && pend_vld_q && !grant[k];

        always_comb begin
            armed_d = armed_q;
            if (hit)           armed_d = 1'b1;   // re-arm wins over completion
            else if (complete) armed_d = 1'b0;

            pend_vld_d = pend_vld_q;
            pend_d     = pend_q;
            if (accept) begin
                pend_vld_d   = 1'b1;
                pend_d.ch    = CHW'(k);
                pend_d.write = write_q;
                pend_d.addr  = addr_q;
                pend_d.data  = write_q ? bus.ch_hwdata_i[32*k +: 32]
                                       : bus.ch_hrdata_i[32*k +: 32];
`ifdef TRACE_TIMESTAMP_EN
                pend_d.ts    = ts_q;
`endif
            end else if (grant[k]) begin
                pend_vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                armed_q    <= 1'b0;
                pend_vld_q <= 1'b0;
            end else begin
                armed_q    <= armed_d;
                pend_vld_q <= pend_vld_d;
            end
            pend_q <= pend_d;
            if (hit) begin
                addr_q  <= haddr;
                write_q <= bus.ch_hwrite_i[k];
            end
        end

        assign pend_vld[k] = pend_vld_q;
        assign pend_rec[k] = pend_q;
    end

    // ---------------- round-robin arbiter ----------------
    assign pop      = rec_valid_o && rec_ready_i;
    assign can_push = (cnt_q != (AW+1)'(DEPTH)) || pop;

    always_comb begin
        grant   = '0;
        push    = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            int             sum;
            logic [CHW-1:0] idx;
            sum = int'(rr_q) + i;
            if (sum >= NUM_CH) sum = sum - NUM_CH;
            idx = CHW'(sum);
            if (!push && pend_vld[idx] && can_push) begin
                grant[idx] = 1'b1;
                push       = 1'b1;
                gnt_idx    = idx;
            end
        end
        rr_d = rr_q;
        if (push) rr_d = (gnt_idx == CHW'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
    end

    // ---------------- show-ahead FIFO ----------------
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            rr_q   <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
        end
        if (push) mem_q[wptr_q] <= pend_rec[gnt_idx];
    end

    // gate the head so an empty FIFO presents all-zero fields
    assign head        = rec_valid_o ? mem_q[rptr_q] : '0;
    assign rec_valid_o = (cnt_q != '0);
    assign rec_ch_o    = head.ch;
    assign rec_write_o = head.write;
    assign rec_addr_o  = head.addr;
    assign rec_data_o  = head.data;
`ifdef TRACE_TIMESTAMP_EN
    assign rec_ts_o    = head.ts;
`else
    assign rec_ts_o    = '0;
`endif
    assign level_o     = cnt_q;

    // ---------------- drop accounting ----------------
    assign drop_sum = {1'b0, drop_q} + 17'($countones(drop));

    always_comb begin
        drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        ovf_d  = ovf_q || (drop != '0);
        if (clr_i) begin
            drop_d = '0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    assign drop_cnt_o = drop_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_ahbl_trace_mon.sv
// tb_ahbl_trace_mon
//   Directed bench for ahbl_trace_mon (NUM_CH=2, DEPTH=4). Expected records
//   are queued when the bench drives a data phase and compared when the DUT
//   hands them out on the record stream.
module tb_ahbl_trace_mon;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en, clr, rec_ready;
    logic [31:0] filt_lo, filt_hi;
    logic        rec_valid, rec_write, ovf;
    logic [0:0]  rec_ch;
    logic [31:0] rec_addr, rec_data, rec_ts;
    logic [15:0] drop_cnt;
    logic [2:0]  level;

    always #5 clk = ~clk;

    ahbl_trace_mon_if #(.NUM_CH(NUM_CH)) bus ();

    ahbl_trace_mon #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .clr_i       (clr),
        .bus         (bus.slave),
        .filt_lo_i   (filt_lo),
        .filt_hi_i   (filt_hi),
        .rec_valid_o (rec_valid),
        .rec_ready_i (rec_ready),
        .rec_ch_o    (rec_ch),
        .rec_write_o (rec_write),
        .rec_addr_o  (rec_addr),
        .rec_data_o  (rec_data),
        .rec_ts_o    (rec_ts),
        .drop_cnt_o  (drop_cnt),
        .ovf_o       (ovf),
        .level_o     (level)
    );

    typedef struct {
        logic [31:0] ch;
        logic [31:0] write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ts;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] cyc;

    // cycle index as the timestamp counter is defined: 0 after reset, +1 per edge
    always @(posedge clk) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 32'd1;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(int k, logic [1:0] tr, logic wr, logic [31:0] a,
                          logic [31:0] wd, logic [31:0] rd, logic rdy);
        bus.ch_htrans_i[2*k +: 2]  = tr;
        bus.ch_hwrite_i[k]         = wr;
        bus.ch_haddr_i[32*k +: 32] = a;
        bus.ch_hwdata_i[32*k +: 32] = wd;
        bus.ch_hrdata_i[32*k +: 32] = rd;
        bus.ch_hready_i[k]         = rdy;
    endtask

    task automatic idle(int k);
        set_ch(k, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    // called in the completion cycle, so cyc equals the timestamp to expect
    task automatic push_exp(int k, logic wr, logic [31:0] a, logic [31:0] d);
        exp_t x;
        x.ch    = k;
        x.write = {31'b0, wr};
        x.addr  = a;
        x.data  = d;
`ifdef TRACE_TIMESTAMP_EN
        x.ts    = cyc;
`else
        x.ts    = 32'h0;
`endif
        sb.push_back(x);
    endtask

    // address phase, optional wait states, data phase, then idle
    task automatic xfer(int k, logic wr, logic [31:0] a, logic [31:0] d,
                        int waits, bit expect_rec);
        tick();
        set_ch(k, 2'b10, wr, a, 32'h0, 32'h0, 1'b1);
        for (int w = 0; w < waits; w++) begin
            tick();
            set_ch(k, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        end
        tick();
        set_ch(k, 2'b00, 1'b0, 32'h0, wr ? d : 32'h0, wr ? 32'h0 : d, 1'b1);
        if (expect_rec) push_exp(k, wr, a, d);
        tick();
        idle(k);
    endtask

    task automatic wait_drain(string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, sb.size(), 32'd0);
    endtask

    // record stream checker
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            n_chk++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_rec: observed addr 0x%08h expected no record", rec_addr);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rec_ch",    {31'b0, rec_ch},    e.ch);
                chk("rec_write", {31'b0, rec_write}, e.write);
                chk("rec_addr",  rec_addr,           e.addr);
                chk("rec_data",  rec_data,           e.data);
                chk("rec_ts",    rec_ts,             e.ts);
            end
        end
    end

    initial begin
        en        = 1'b1;
        clr       = 1'b0;
        rec_ready = 1'b1;
        filt_lo   = 32'h0;
        filt_hi   = 32'hFFFF_FFFF;
        idle(0);
        idle(1);
        rst = 1'b1;
        repeat (3) tick();

        // reset state
        chk("rst_valid", {31'b0, rec_valid}, 32'd0);
        chk("rst_level", {29'b0, level},     32'd0);
        chk("rst_drop",  {16'b0, drop_cnt},  32'd0);
        chk("rst_ovf",   {31'b0, ovf},       32'd0);
        chk("rst_addr",  rec_addr,           32'd0);
        chk("rst_ts",    rec_ts,             32'd0);
        rst = 1'b0;
        tick();

        // ch0 single write, latency: valid two cycles after the data phase
        tick();
        set_ch(0, 2'b10, 1'b1, 32'h0000_1000, 32'h0, 32'h0, 1'b1);
        tick();
        set_ch(0, 2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1);
        push_exp(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        chk("lat_n0", {31'b0, rec_valid}, 32'd0);
        tick();
        idle(0);
        chk("lat_n1", {31'b0, rec_valid}, 32'd0);
        tick();
        chk("lat_n2", {31'b0, rec_valid}, 32'd1);
        wait_drain("drain_wr");

        // ch1 read with 3 wait states
        xfer(1, 1'b0, 32'h2000_0040, 32'h1234_5678, 3, 1'b1);
        repeat (5) tick();
        wait_drain("drain_rd");

        // both channels complete together; last grant was ch1, so ch0 leads
        tick();
        set_ch(0, 2'b10, 1'b1, 32'h0000_5000, 32'h0, 32'h0, 1'b1);
        set_ch(1, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 32'h0, 1'b1);
        tick();
        set_ch(0, 2'b00, 1'b0, 32'h0, 32'hAAAA_0000, 32'h0, 1'b1);
        set_ch(1, 2'b00, 1'b0, 32'h0, 32'h0, 32'hBBBB_1111, 1'b1);
        push_exp(0, 1'b1, 32'h0000_5000, 32'hAAAA_0000);
        push_exp(1, 1'b0, 32'h0000_6000, 32'hBBBB_1111);
        tick();
        idle(0);
        idle(1);
        wait_drain("drain_pair0");

        // a lone ch0 grant moves priority to ch1, then repeat the pair
        xfer(0, 1'b1, 32'h0000_7000, 32'h0707_0707, 0, 1'b1);
        wait_drain("drain_lone");
        tick();
        set_ch(0, 2'b10, 1'b1, 32'h0000_5004, 32'h0, 32'h0, 1'b1);
        set_ch(1, 2'b10, 1'b0, 32'h0000_6004, 32'h0, 32'h0, 1'b1);
        tick();
        set_ch(0, 2'b00, 1'b0, 32'h0, 32'hAAAA_0001, 32'h0, 1'b1);
        set_ch(1, 2'b00, 1'b0, 32'h0, 32'h0, 32'hBBBB_2222, 1'b1);
        push_exp(1, 1'b0, 32'h0000_6004, 32'hBBBB_2222);
        push_exp(0, 1'b1, 32'h0000_5004, 32'hAAAA_0001);
        tick();
        idle(0);
        idle(1);
        wait_drain("drain_pair1");

        // address window edges
        filt_lo = 32'h0000_2000;
        filt_hi = 32'h0000_2FFF;
        xfer(0, 1'b0, 32'h0000_1FFC, 32'h1111_1FFC, 0, 1'b0);
        xfer(0, 1'b0, 32'h0000_2000, 32'h2222_2000, 0, 1'b1);
        xfer(0, 1'b0, 32'h0000_2FFC, 32'h3333_2FFC, 0, 1'b1);
        xfer(0, 1'b0, 32'h0000_3000, 32'h4444_3000, 0, 1'b0);
        // inverted window captures nothing
        filt_lo = 32'h0000_3000;
        filt_hi = 32'h0000_2000;
        xfer(1, 1'b1, 32'h0000_2800, 32'h5555_2800, 0, 1'b0);
        filt_lo = 32'h0;
        filt_hi = 32'hFFFF_FFFF;
        repeat (4) tick();
        wait_drain("drain_win");

        // en_i low blocks a new capture
        en = 1'b0;
        xfer(0, 1'b1, 32'h0000_8000, 32'h8888_8888, 0, 1'b0);
        en = 1'b1;
        // dropping en_i after arming still records the transfer
        tick();
        set_ch(1, 2'b10, 1'b1, 32'h0000_9000, 32'h0, 32'h0, 1'b1);
        tick();
        en = 1'b0;
        set_ch(1, 2'b00, 1'b0, 32'h0, 32'h9999_9999, 32'h0, 1'b1);
        push_exp(1, 1'b1, 32'h0000_9000, 32'h9999_9999);
        tick();
        idle(1);
        en = 1'b1;
        repeat (4) tick();
        wait_drain("drain_en");

        // overflow: 10 back-to-back writes with the stream stalled
        rec_ready = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            if (i < 10) set_ch(0, 2'b10, 1'b1, 32'h0000_0100 + 32'(4*i), 32'h0, 32'h0, 1'b1);
            else        set_ch(0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
            if (i > 0) begin
                bus.ch_hwdata_i[31:0] = 32'hC000_0000 + 32'(i-1);
                if (i - 1 < 5) push_exp(0, 1'b1, 32'h0000_0100 + 32'(4*(i-1)), 32'hC000_0000 + 32'(i-1));
            end
        end
        tick();
        idle(0);
        repeat (3) tick();
        chk("ovf_level", {29'b0, level},    32'd4);
        chk("ovf_drop",  {16'b0, drop_cnt}, 32'd5);
        chk("ovf_flag",  {31'b0, ovf},      32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_drop",  {16'b0, drop_cnt}, 32'd0);
        chk("clr_ovf",   {31'b0, ovf},      32'd0);
        chk("clr_level", {29'b0, level},    32'd4);
        rec_ready = 1'b1;
        wait_drain("drain_ovf");
        tick();
        chk("ovf_empty", {29'b0, level}, 32'd0);

        // reset with 3 records buffered and a transfer armed
        rec_ready = 1'b0;
        xfer(1, 1'b1, 32'h0000_A000, 32'hA000_0000, 0, 1'b1);
        xfer(1, 1'b1, 32'h0000_A004, 32'hA000_0004, 0, 1'b1);
        xfer(1, 1'b1, 32'h0000_A008, 32'hA000_0008, 0, 1'b1);
        repeat (3) tick();
        chk("pre_rst_level", {29'b0, level}, 32'd3);
        set_ch(0, 2'b10, 1'b1, 32'h0000_B000, 32'h0, 32'h0, 1'b1);
        tick();
        set_ch(0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        tick();
        sb.delete();
        chk("rst_mid_valid", {31'b0, rec_valid}, 32'd0);
        chk("rst_mid_level", {29'b0, level},     32'd0);
        rst = 1'b0;
        // interrupted data phase finishes now; nothing may be recorded
        set_ch(0, 2'b00, 1'b0, 32'h0, 32'hBAD0_BAD0, 32'h0, 1'b1);
        rec_ready = 1'b1;
        tick();
        idle(0);
        repeat (10) tick();
        chk("post_rst_level", {29'b0, level}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // absolute backstop against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

endmodule
